// File: rtl/bus_arb_pkg.sv
// Shared encodings for the dual-master bus arbiter: FSM states, slave map, master ids.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int NUM_SLAVES = 3;
    localparam int SLV0       = 0;
    localparam int SLV1       = 1;
    localparam int SLV2       = 2;

    // Slave-select field inside the master address.
    localparam int SEL_HI = 13;
    localparam int SEL_LO = 12;

    // Master identifiers, also the encoding of the round-robin pointer.
    localparam logic M1 = 1'b0;
    localparam logic M2 = 1'b1;

endpackage

// File: rtl/bus_addr_decoder.sv
// Maps a master address onto a one-hot slave select, flagging the unmapped quarter.
// Latency: purely combinational.
// Backpressure: none; output follows the address.
module bus_addr_decoder
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  invalid
);

    // Bits outside the select field play no part in slave selection.
    logic unused_bits;
    assign unused_bits = ^{addr[ADDR_W-1:SEL_HI+1], addr[SEL_LO-1:0]};

    // Select field to one-hot slave; the top quarter maps to nothing.
    always_comb begin
        sel     = '0;
        invalid = 1'b0;
        case (addr[SEL_HI:SEL_LO])
            2'b00:   sel[SLV0] = 1'b1;
            2'b01:   sel[SLV1] = 1'b1;
            2'b10:   sel[SLV2] = 1'b1;
            default: invalid   = 1'b1;
        endcase
    end

endmodule

// File: rtl/dual_master_bus_arbiter.sv
// Round-robin arbiter sharing one bus between two masters and three slaves.
// Latency: grant one cycle after request, completion pulse two cycles after grant at best.
// Backpressure: waits on the selected slave's ready, completing with error after TIMEOUT cycles.
module dual_master_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int SADDR_W = 12,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m1_req,
    input  logic [ADDR_W-1:0]            m1_addr,
    input  logic [DATA_W-1:0]            m1_wdata,
    input  logic                         m1_wen,
    output logic                         m1_grant,
    output logic [DATA_W-1:0]            m1_rdata,
    output logic                         m1_ready,
    output logic                         m1_err,
    input  logic                         m2_req,
    input  logic [ADDR_W-1:0]            m2_addr,
    input  logic [DATA_W-1:0]            m2_wdata,
    input  logic                         m2_wen,
    output logic                         m2_grant,
    output logic [DATA_W-1:0]            m2_rdata,
    output logic                         m2_ready,
    output logic                         m2_err,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [SADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic                         s_wen,
    output logic                         s_valid,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready
);

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t                  state, state_nxt;
    logic                    owner, rr_last;
    logic [SADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]       wdata_q, rdata_q;
    logic                    wen_q, inv_q, err_q;
    logic [NUM_SLAVES-1:0]   sel_q;
    logic [CNT_W-1:0]        cnt_q;

    logic                    any_req, pick;
    logic [ADDR_W-1:0]       pick_addr;
    logic [DATA_W-1:0]       pick_wdata, sel_rdata;
    logic                    pick_wen, dec_inv, ready_hit, timeout_hit;
    logic [NUM_SLAVES-1:0]   dec_sel;

    assign any_req     = m1_req | m2_req;
    assign ready_hit   = |(s_ready & sel_q);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Choose a master: the sole requester, or on a tie whoever was not served last.
    always_comb begin
        pick = M1;
        if (m1_req && m2_req) pick = (rr_last == M1) ? M2 : M1;
        else if (m2_req)      pick = M2;
        pick_addr  = (pick == M2) ? m2_addr  : m1_addr;
        pick_wdata = (pick == M2) ? m2_wdata : m1_wdata;
        pick_wen   = (pick == M2) ? m2_wen   : m1_wen;
    end

    bus_addr_decoder #(.ADDR_W(ADDR_W)) u_dec (
        .addr    (pick_addr),
        .sel     (dec_sel),
        .invalid (dec_inv)
    );

    // Read data from whichever slave the latched select points at.
    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            if (sel_q[k]) sel_rdata = sel_rdata | s_rdata[k*DATA_W +: DATA_W];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and bus/master outputs, all decoded from the current state.
    always_comb begin
        state_nxt = state;
        m1_grant  = 1'b0;
        m1_ready  = 1'b0;
        m1_err    = 1'b0;
        m1_rdata  = '0;
        m2_grant  = 1'b0;
        m2_ready  = 1'b0;
        m2_err    = 1'b0;
        m2_rdata  = '0;
        s_sel     = '0;
        s_valid   = 1'b0;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = inv_q ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (ready_hit || timeout_hit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE) begin
            s_sel    = sel_q;
            m1_grant = (owner == M1);
            m2_grant = (owner == M2);
        end
        s_valid = (state == ST_GRANT) && !inv_q;
        if (state == ST_DONE) begin
            m1_ready = (owner == M1);
            m2_ready = (owner == M2);
            m1_err   = (owner == M1) && err_q;
            m2_err   = (owner == M2) && err_q;
            m1_rdata = (owner == M1) ? rdata_q : '0;
            m2_rdata = (owner == M2) ? rdata_q : '0;
        end
    end

    // Transfer context: latch on pick, count and capture in WAIT, rotate priority on DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= M1;
            rr_last <= M2;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            sel_q   <= '0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (any_req) begin
                    owner   <= pick;
                    addr_q  <= pick_addr[SADDR_W-1:0];
                    wdata_q <= pick_wdata;
                    wen_q   <= pick_wen;
                    sel_q   <= dec_sel;
                    inv_q   <= dec_inv;
                    cnt_q   <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                ST_GRANT: if (inv_q) err_q <= 1'b1;
                ST_WAIT: begin
                    if (ready_hit) begin
                        rdata_q <= wen_q ? '0 : sel_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: rr_last <= owner;
                default: ;
            endcase
        end
    end

    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_wen   = wen_q;

endmodule

// File: tb/tb_dual_master_bus_arbiter.sv
module tb_dual_master_bus_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        m1_req, m1_wen, m2_req, m2_wen;
    logic [15:0] m1_addr, m2_addr;
    logic [7:0]  m1_wdata, m2_wdata;
    logic        m1_grant, m1_ready, m1_err, m2_grant, m2_ready, m2_err;
    logic [7:0]  m1_rdata, m2_rdata;
    logic [2:0]  s_sel;
    logic [11:0] s_addr;
    logic [7:0]  s_wdata;
    logic        s_wen, s_valid;
    logic [23:0] s_rdata;
    logic [2:0]  s_ready;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dual_master_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .SADDR_W(12), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wen(m1_wen),
        .m1_grant(m1_grant), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .m2_req(m2_req), .m2_addr(m2_addr), .m2_wdata(m2_wdata), .m2_wen(m2_wen),
        .m2_grant(m2_grant), .m2_rdata(m2_rdata), .m2_ready(m2_ready), .m2_err(m2_err),
        .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen), .s_valid(s_valid),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {17'd0, m1_grant, m1_rdata, m1_ready, m1_err,
                m2_grant, m2_rdata, m2_ready, m2_err,
                s_sel, s_addr, s_wdata, s_wen, s_valid};
    endfunction

    // Transaction-level model: a transfer is described by its owner, its
    // cycle offset from the grant cycle, and the offset of its completion.
    bit          mbusy, mown, mlast, minv, mwen, merr;
    int          mt, mfin, midx;
    logic [2:0]  msel;
    logic [11:0] maddr;
    logic [7:0]  mwd, mrd;
    logic [15:0] ma;

    always @(posedge clk) begin
        if (rst) begin
            mbusy = 0; mlast = 1; maddr = '0; mwd = '0; mwen = 0; msel = '0;
            minv = 0; mt = 0; mfin = -1; merr = 0; mrd = '0;
        end else if (!mbusy) begin
            if (m1_req || m2_req) begin
                if (m1_req && m2_req) mown = (mlast == 0) ? 1'b1 : 1'b0;
                else                  mown = m2_req;
                ma    = mown ? m2_addr  : m1_addr;
                mwd   = mown ? m2_wdata : m1_wdata;
                mwen  = mown ? m2_wen   : m1_wen;
                maddr = ma[11:0];
                midx  = int'(ma[13:12]);
                minv  = (midx == 3);
                msel  = minv ? 3'b000 : 3'(1 << midx);
                mbusy = 1; mt = 0; mrd = '0;
                mfin  = minv ? 1 : -1;
                merr  = minv;
            end
        end else begin
            if (mt == mfin) begin
                mbusy = 0;
                mlast = mown;
            end else begin
                if (!minv && mfin < 0 && mt >= 1) begin
                    if (s_ready[midx]) begin
                        mfin = mt + 1; merr = 0;
                        mrd  = mwen ? 8'h00 : s_rdata[midx*8 +: 8];
                    end else if (mt == TIMEOUT) begin
                        mfin = mt + 1; merr = 1; mrd = 8'h00;
                    end
                end
                mt++;
            end
        end
    end

    function automatic logic [63:0] exp_vec();
        bit g1, g2, r1, r2;
        g1 = mbusy && !mown;
        g2 = mbusy && mown;
        r1 = g1 && (mt == mfin);
        r2 = g2 && (mt == mfin);
        return {17'd0, g1, (r1 ? mrd : 8'h00), r1, r1 & merr,
                g2, (r2 ? mrd : 8'h00), r2, r2 & merr,
                (mbusy ? msel : 3'b000), maddr, mwd, mwen,
                mbusy && (mt == 0) && !minv};
    endfunction

    // Every cycle, away from the active edge, the DUT must match the model.
    always @(negedge clk) begin
        if (chk_en) chk("cycle_outputs", out_vec(), exp_vec());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int order[4];
    int cyc[4];
    int k, n;
    bit seen;

    initial begin
        rst = 1; m1_req = 0; m2_req = 0; m1_wen = 0; m2_wen = 0;
        m1_addr = '0; m2_addr = '0; m1_wdata = '0; m2_wdata = '0;
        s_rdata = 24'hAA3411; s_ready = '0;
        tick();
        chk_en = 1;
        chk("reset_outputs", out_vec(), 64'd0);
        rst = 0;
        tick();

        // 1: M1 write 0x0ABC = 0x55, slave0 ready in second WAIT cycle
        m1_addr = 16'h0ABC; m1_wdata = 8'h55; m1_wen = 1; m1_req = 1;
        tick();
        chk("t1_grant_valid_wen", {m1_grant, m2_grant, s_valid, s_wen}, 4'b1011);
        chk("t1_sel", s_sel, 3'b001);
        chk("t1_addr", s_addr, 12'hABC);
        chk("t1_wdata", s_wdata, 8'h55);
        s_ready = 3'b110;
        tick();
        chk("t1_wait0", {m1_ready, s_valid}, 2'b00);
        tick();
        chk("t1_wait1", {m1_ready, s_valid}, 2'b00);
        s_ready = 3'b001;
        tick();
        chk("t1_done", {m1_ready, m1_err, m1_rdata, m2_grant, m2_ready}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        m1_req = 0; s_ready = '0;
        tick();
        chk("t1_idle", {m1_grant, s_sel}, 4'b0000);

        // 2: M1 read 0x12C5 from slave1, minimum latency
        m1_addr = 16'h12C5; m1_wen = 0; m1_req = 1; s_ready = 3'b010;
        tick();
        chk("t2_sel", s_sel, 3'b010);
        chk("t2_addr", s_addr, 12'h2C5);
        tick();
        tick();
        chk("t2_done", {m1_ready, m1_err, m1_rdata}, {1'b1, 1'b0, 8'h34});
        m1_req = 0; s_ready = '0;
        tick();

        // 4: M2 access to the unmapped quarter
        m2_addr = 16'h3000; m2_wen = 0; m2_req = 1;
        tick();
        chk("t4_grant", {m2_grant, s_valid, s_sel}, 5'b10000);
        tick();
        chk("t4_done", {m2_ready, m2_err, m2_rdata}, {1'b1, 1'b1, 8'h00});
        chk("t4_m1_quiet", {m1_grant, m1_ready, m1_err, m1_rdata}, 11'd0);
        m2_req = 0;
        tick();

        // 3: simultaneous requests straight out of reset alternate M1, M2, ...
        rst = 1;
        tick();
        chk("t3_reset", out_vec(), 64'd0);
        rst = 0;
        m1_addr = 16'h0001; m1_wen = 0; m2_addr = 16'h1002; m2_wen = 0;
        s_ready = 3'b111; m1_req = 1; m2_req = 1;
        k = 0;
        for (n = 1; n <= 40 && k < 4; n++) begin
            tick();
            if (m1_ready) begin order[k] = 1; cyc[k] = n; k++; end
            else if (m2_ready) begin order[k] = 2; cyc[k] = n; k++; end
        end
        m1_req = 0; m2_req = 0;
        chk("t3_completions", k, 4);
        if (k == 4) begin
            chk("t3_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b01_10_01_10);
            chk("t3_first_latency", cyc[0], 3);
            chk("t3_gap01", cyc[1] - cyc[0], 4);
            chk("t3_gap12", cyc[2] - cyc[1], 4);
        end
        s_ready = '0;
        tick();

        // 5: slave2 never answers; timeout, then a normal transfer
        m1_addr = 16'h2000; m1_wen = 0; m1_req = 1; s_ready = 3'b011;
        seen = 0;
        for (n = 1; n <= TIMEOUT + 10 && !seen; n++) begin
            tick();
            if (m1_ready) begin
                seen = 1;
                chk("t5_timeout_cycles", n, TIMEOUT + 2);
                chk("t5_timeout_err", {m1_err, m1_rdata}, {1'b1, 8'h00});
            end
        end
        chk("t5_timeout_seen", seen, 1'b1);
        m1_req = 0; s_ready = '0;
        tick();
        m1_addr = 16'h2001; m1_req = 1; s_ready = 3'b100;
        tick();
        tick();
        tick();
        chk("t5_after", {m1_ready, m1_err, m1_rdata}, {1'b1, 1'b0, 8'hAA});
        m1_req = 0; s_ready = '0;
        tick();

        // 6: reset while waiting aborts without a completion pulse
        m1_addr = 16'h0000; m1_wen = 0; m1_req = 1;
        tick();
        tick();
        tick();
        chk("t6_in_wait", {m1_grant, s_sel}, 4'b1001);
        rst = 1; m1_req = 0;
        tick();
        chk("t6_reset_outputs", out_vec(), 64'd0);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_ready", {m1_grant, m1_ready}, 2'b00);
        end

        tick();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
